// File: rtl/mem_arb_pkg.sv
// Shared types and grant encodings for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational tie-breaker: returns 1 when master 1 wins arbitration.
// ARB_ROUND_ROBIN_EN selects alternating ties; otherwise master 0 has fixed priority.
module mem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic pick1
);

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the master that did not complete last wins.
  always_comb pick1 = req1 & (~req0 | ~last_grant);
`else
  logic unused_last_grant;
  always_comb unused_last_grant = last_grant;
  always_comb pick1 = req1 & ~req0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one PicoRV32-native memory slave port.
// Tie policy is set in mem_arb_pick via ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  input  logic                m0_instr,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_lock,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic                m1_instr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_lock,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic                s_instr,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant
);

  arb_state_t state;
  logic       last_grant;
  logic [1:0] grant_q;
  logic       pick1;

  mem_arb_pick u_pick (
    .req0       (m0_valid),
    .req1       (m1_valid),
    .last_grant (last_grant),
    .pick1      (pick1)
  );

  // grant_q is kept in lockstep with state so grant is a clean register output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_q    <= GRANT_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            state   <= pick1 ? GNT1 : GNT0;
            grant_q <= pick1 ? GRANT_M1 : GRANT_M0;
          end
        end
        GNT0: begin
          if (!m0_valid) begin
            state   <= IDLE;
            grant_q <= GRANT_NONE;
          end else if (s_ready) begin
            last_grant <= 1'b0;
            if (!m0_lock) begin
              state   <= IDLE;
              grant_q <= GRANT_NONE;
            end
          end
        end
        GNT1: begin
          if (!m1_valid) begin
            state   <= IDLE;
            grant_q <= GRANT_NONE;
          end else if (s_ready) begin
            last_grant <= 1'b1;
            if (!m1_lock) begin
              state   <= IDLE;
              grant_q <= GRANT_NONE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= GRANT_NONE;
        end
      endcase
    end
  end

  assign grant = grant_q;

  always_comb begin
    s_valid  = '0;
    s_instr  = '0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = '0;
    m0_rdata = '0;
    m1_ready = '0;
    m1_rdata = '0;
    case (state)
      GNT0: begin
        s_valid  = m0_valid;
        s_instr  = m0_instr;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready;
        m0_rdata = s_rdata;
      end
      GNT1: begin
        s_valid  = m1_valid;
        s_instr  = m1_instr;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready;
        m1_rdata = s_rdata;
      end
      default: ;
    endcase
  end

endmodule
